// File: rtl/l0_pkg.sv
// l0_pkg: shared defaults and FSM encoding for the L0 feeder.
// Holds lane geometry, SRAM address width and the state enum.
package l0_pkg;
  localparam int ROW    = 8;
  localparam int BW     = 4;
  localparam int ADDR_W = 11;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;
endpackage

// File: rtl/l0_feeder_skid.sv
// l0_feeder_skid: 2-entry in-order buffer for returning SRAM words.
// Ports: clk, reset (async low), push/data in, pop, head out, count.
module l0_feeder_skid
  import l0_pkg::*;
#(
  parameter int W = ROW * BW
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] data,
  output logic [W-1:0] head,
  output logic [1:0]   count
);

  logic [W-1:0] r_d0;
  logic [W-1:0] r_d1;
  logic [1:0]   r_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_d0  <= '0;
      r_d1  <= '0;
      r_cnt <= '0;
    end else begin
      unique case ({push, pop})
        2'b10: begin
          if (r_cnt == 2'd0) r_d0 <= data;
          else               r_d1 <= data;
          r_cnt <= r_cnt + 2'd1;
        end
        2'b01: begin
          r_d0  <= r_d1;
          r_cnt <= r_cnt - 2'd1;
        end
        2'b11: begin
          // Count stays put; head advances if a second entry is queued.
          if (r_cnt == 2'd2) begin
            r_d0 <= r_d1;
            r_d1 <= data;
          end else begin
            r_d0 <= data;
          end
        end
        default: ;
      endcase
    end
  end

  assign head  = r_d0;
  assign count = r_cnt;

endmodule

// File: rtl/l0_feeder.sv
// l0_feeder: streams num_vec SRAM words from base_addr into L0.
// Ports: start/base_addr/num_vec, SRAM read port, L0 write port, busy/done.
module l0_feeder
  import l0_pkg::*;
#(
  parameter int row    = ROW,
  parameter int bw     = BW,
  parameter int addr_w = ADDR_W
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [addr_w-1:0]   base_addr,
  input  logic [addr_w:0]     num_vec,
  output logic                sram_cen,
  output logic                sram_wen,
  output logic [addr_w-1:0]   sram_addr,
  input  logic [row*bw-1:0]   sram_q,
  output logic                l0_wr,
  output logic [row*bw-1:0]   l0_in,
  input  logic                l0_full,
  output logic                busy,
  output logic                done
);

  localparam int CW = addr_w + 1;

  state_t            r_state;
  state_t            w_next;
  logic [addr_w-1:0] r_addr;
  logic [CW-1:0]     r_rem;
  logic [CW-1:0]     r_wr_left;
  logic              r_inflight;
  logic              r_done;

  logic [1:0]        w_count;
  logic [2:0]        w_occ;
  logic              w_rd;
  logic              w_accept;
  logic              w_zero;
  logic              w_last_wr;

  assign w_accept = start && (r_state == IDLE)
                    && (num_vec != '0);
  assign w_zero   = start && (r_state == IDLE)
                    && (num_vec == '0);

  assign l0_wr = (w_count != 2'd0) && !l0_full;

  // Words already committed to arrive, less the one leaving now.
  assign w_occ = {2'b0, r_inflight}
               + {1'b0, w_count}
               - {2'b0, l0_wr};

  // First read goes out in the start cycle so L0 sees data at +2.
  assign w_rd = w_accept
             || ((r_state == RUN) && (r_rem != '0)
                 && (w_occ < 3'd2));

  assign w_last_wr = l0_wr && (r_wr_left == CW'(1));

  assign sram_cen  = !w_rd;
  assign sram_wen  = 1'b1;
  assign sram_addr = (r_state == IDLE) ? base_addr : r_addr;
  assign busy      = (r_state != IDLE);
  assign done      = r_done;

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE: begin
        if (w_accept) w_next = RUN;
      end
      RUN: begin
        if ((r_rem == '0)
            || (w_rd && (r_rem == CW'(1))))
          w_next = DRAIN;
      end
      DRAIN: begin
        if (w_last_wr) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= IDLE;
      r_addr     <= '0;
      r_rem      <= '0;
      r_wr_left  <= '0;
      r_inflight <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_state    <= w_next;
      r_inflight <= w_rd;
      r_done     <= w_zero
                 || ((r_state == DRAIN) && w_last_wr);
      if (w_accept) begin
        r_addr    <= base_addr + addr_w'(1);
        r_rem     <= num_vec - CW'(1);
        r_wr_left <= num_vec;
      end else begin
        if (w_rd) begin
          r_addr <= r_addr + addr_w'(1);
          r_rem  <= r_rem - CW'(1);
        end
        if (l0_wr) r_wr_left <= r_wr_left - CW'(1);
      end
    end
  end

  l0_feeder_skid #(
    .W (row * bw)
  ) u_skid (
    .clk   (clk),
    .reset (reset),
    .push  (r_inflight),
    .pop   (l0_wr),
    .data  (sram_q),
    .head  (l0_in),
    .count (w_count)
  );

endmodule

// File: doc/l0_feeder.md
L0_FEEDER -- requirements
Module: l0_feeder

Interface
REQ-001 SHALL have parameters: row, default 8, vector lanes; bw, default 4, bits per lane; addr_w, default 11, activation SRAM address width.
REQ-002 SHALL have ports: clk  in  1  sole clock, rising edge; reset  in  1  asynchronous, active-low.
REQ-003 SHALL have ports: start  in  1  one-cycle launch pulse; base_addr  in  addr_w  first SRAM word; num_vec  in  addr_w+1  vector count, 0 legal.
REQ-004 SHALL have ports: sram_cen  out  1  active-low read enable; sram_wen  out  1  held 1 (read-only); sram_addr  out  addr_w; sram_q  in  row*bw  read data.
REQ-005 SHALL have ports: l0_wr  out  1  L0 write strobe; l0_in  out  row*bw  L0 write data; l0_full  in  1  L0 any-lane full.
REQ-006 SHALL have ports: busy  out  1  transfer in progress; done  out  1  one-cycle completion pulse.

Function
REQ-007 SHALL move num_vec consecutive SRAM words, base_addr upward, into L0 in address order, one vector per l0_wr.
REQ-008 SHALL use SRAM read latency of exactly one cycle: word addressed while sram_cen=0 at edge t is valid on sram_q during cycle t+1.
REQ-009 SHALL compute address as base_addr+k modulo 2^addr_w (wrap from all-ones to 0).
REQ-010 SHALL implement FSM IDLE -> RUN -> DRAIN -> IDLE: IDLE->RUN on start with num_vec>0; RUN->DRAIN after last read issued; DRAIN->IDLE after last l0_wr.
REQ-011 SHALL, on start with num_vec=0, remain IDLE, issue no reads and pulse done the following cycle.
REQ-012 SHALL ignore start while busy=1; base_addr/num_vec are sampled only on an accepted start.
REQ-013 SHALL capture returning SRAM data into a 2-entry in-order buffer; l0_wr = buffer-not-empty AND NOT l0_full, combinationally; l0_in = buffer head.
REQ-014 SHALL issue a read only when reads remain and (in-flight reads + buffered entries - write this cycle) < 2; no data ever dropped or duplicated.
REQ-015 SHALL sustain one vector per cycle when l0_full stays 0; first l0_wr two cycles after start.
REQ-016 SHALL tolerate l0_full asserting/deasserting any cycle, including the cycle a read returns; writes resume the cycle l0_full falls.
REQ-017 SHALL assert busy from the cycle after accepted start through the last l0_wr cycle inclusive; done pulses the cycle after the last l0_wr, with busy=0.
REQ-018 SHALL hold sram_cen=1 whenever no read is issued; sram_addr is don't-care then.

Reset
REQ-019 SHALL, on reset=0, asynchronously force: state IDLE, busy 0, done 0, sram_cen 1, sram_wen 1, l0_wr 0, buffer empty, counters 0.
REQ-020 SHALL, on reset mid-transfer, discard in-flight and buffered data; no l0_wr after reset release until a new start.
REQ-021 SHALL start operation on the first rising clk edge after reset deasserts.

Structure
REQ-022 SHALL place row, bw, addr_w defaults and FSM state encoding (IDLE, RUN, DRAIN) in shared package l0_pkg.
REQ-023 SHALL implement the 2-entry buffer as sub-module l0_feeder_skid (push, pop, data, count); all else in l0_feeder.

Verification
REQ-024 Bench SHALL cover: start, base_addr=0x010, num_vec=4, l0_full=0 -> sram_addr 0x010..0x013 on 4 consecutive cycles, l0_wr on 4 consecutive cycles from start+2, done at start+6.
REQ-025 Bench SHALL cover: num_vec=6, l0_full high for 3 cycles from first l0_wr -> all 6 vectors written in order, at most 2 reads outstanding, no loss.
REQ-026 Bench SHALL cover: base_addr=0x7FE, num_vec=3 -> addresses 0x7FE, 0x7FF, 0x000.
REQ-027 Bench SHALL cover: num_vec=0 -> no sram_cen=0, no l0_wr, done one cycle after start, busy never 1.
REQ-028 Bench SHALL cover: reset=0 asserted mid-transfer of 8 vectors -> outputs at reset values immediately; start pulse while busy ignored (second run completes only its own count).
